// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared encodings, FSM states and defaults for the data memory responder
package mips_mem_pkg;

   localparam int DEFAULT_DEPTH_BYTES = 1024;
   localparam int DEFAULT_LATENCY     = 2;

   typedef enum logic [1:0] {
      SIZE_BYTE    = 2'b00,
      SIZE_HALF    = 2'b01,
      SIZE_WORD    = 2'b10,
      SIZE_ILLEGAL = 2'b11
   } mem_size_e;

   typedef enum logic [1:0] {
      CLEAR,
      IDLE,
      WAIT,
      RESP
   } state_e;

   // Number of bytes touched by an access; illegal size reports 4 but is rejected elsewhere.
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SIZE_BYTE: return 3'd1;
         SIZE_HALF: return 3'd2;
         default:   return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - big-endian byte-lane insert for stores and extract/extend for loads
module mem_lane_align
   import mips_mem_pkg::*;
(
   input  logic [31:0] word_in,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] wdata,
   output logic [31:0] word_out,
   output logic [31:0] load_data
);

   logic [4:0]  shift;
   logic [31:0] lane_mask;
   logic [31:0] raw;

   // Byte offset 0 is the most significant lane, so the shift counts down from the top.
   always_comb begin
      shift     = '0;
      lane_mask = 32'hFFFF_FFFF;
      case (size)
         SIZE_BYTE: begin
            shift     = {2'd3 - offset, 3'b000};
            lane_mask = 32'h0000_00FF;
         end
         SIZE_HALF: begin
            shift     = {2'd2 - offset, 3'b000};
            lane_mask = 32'h0000_FFFF;
         end
         default: begin
            shift     = '0;
            lane_mask = 32'hFFFF_FFFF;
         end
      endcase

      word_out = (word_in & ~(lane_mask << shift)) | ((wdata & lane_mask) << shift);
      raw      = (word_in >> shift) & lane_mask;

      case (size)
         SIZE_BYTE: load_data = sign_ext ? {{24{raw[7]}}, raw[7:0]} : raw;
         SIZE_HALF: load_data = sign_ext ? {{16{raw[15]}}, raw[15:0]} : raw;
         default:   load_data = raw;
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-port data memory with clear-on-reset and fixed response latency
module data_mem_responder
   import mips_mem_pkg::*;
#(
   parameter int DEPTH_BYTES = DEFAULT_DEPTH_BYTES,
   parameter int LATENCY     = DEFAULT_LATENCY
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int WORDS = DEPTH_BYTES / 4;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   logic [31:0]      mem [WORDS];
   state_e           state;
   logic [IDX_W-1:0] clr_idx;
   logic [3:0]       wait_cnt;
   logic [31:0]      pend_rdata;
   logic             pend_err;

   logic [IDX_W-1:0] word_idx;
   logic [31:0]      cur_word;
   logic [31:0]      merged_word;
   logic [31:0]      load_data;
   logic [31:0]      acc_rdata;
   logic [2:0]       nbytes;
   logic             req_err;

   assign word_idx = req_addr[IDX_W+1:2];
   assign cur_word = mem[word_idx];

   mem_lane_align u_align (
      .word_in   (cur_word),
      .offset    (req_addr[1:0]),
      .size      (req_size),
      .sign_ext  (req_signed),
      .wdata     (req_wdata),
      .word_out  (merged_word),
      .load_data (load_data)
   );

   // Reject illegal size, misalignment, and any access running past the end of the array.
   always_comb begin
      nbytes  = size_bytes(req_size);
      req_err = 1'b0;
      if (req_size == SIZE_ILLEGAL)
         req_err = 1'b1;
      else if (req_size == SIZE_HALF && req_addr[0])
         req_err = 1'b1;
      else if (req_size == SIZE_WORD && req_addr[1:0] != 2'b00)
         req_err = 1'b1;
      else if (({1'b0, req_addr} + {30'd0, nbytes}) > 33'(DEPTH_BYTES))
         req_err = 1'b1;
      acc_rdata = (req_err || req_write) ? 32'd0 : load_data;
   end

   // Control FSM: clear the array, accept one request, age it, then hold the response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= CLEAR;
         clr_idx    <= '0;
         wait_cnt   <= '0;
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         pend_rdata <= '0;
         pend_err   <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               mem[clr_idx] <= '0;
               if (clr_idx == LAST_IDX) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
               end else begin
                  clr_idx <= clr_idx + 1'b1;
               end
            end
            IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  if (!req_err && req_write)
                     mem[word_idx] <= merged_word;
                  if (LATENCY == 1) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_rdata <= acc_rdata;
                     resp_err   <= req_err;
                  end else begin
                     state      <= WAIT;
                     wait_cnt   <= CNT_INIT;
                     pend_rdata <= acc_rdata;
                     pend_err   <= req_err;
                  end
               end
            end
            WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= pend_rdata;
                  resp_err   <= pend_err;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  req_ready  <= 1'b1;
                  resp_valid <= 1'b0;
                  resp_rdata <= '0;
                  resp_err   <= 1'b0;
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized bench with a byte-array reference model for data_mem_responder
module tb_data_mem_responder;
   import mips_mem_pkg::*;

   localparam int DEPTH = 1024;
   localparam int WORDS = DEPTH / 4;
   localparam int LAT   = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [1:0]  req_size = '0;
   logic        req_signed = 1'b0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int total = 0;
   int bad   = 0;

   data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
      end
   endfunction

   // Reference model: byte array plus edge-count timeline.
   logic [7:0]  m_mem [DEPTH];
   bit          m_init = 1'b0;
   bit          m_busy = 1'b0;
   int          m_edge = 0;
   int          m_idle_from = 0;
   int          m_resp_at = 0;
   logic [31:0] m_rdata = '0;
   logic        m_err = 1'b0;

   task automatic model_step();
      bit          rdy_b, vld_b, err;
      int          nb;
      longint      a;
      logic [31:0] v;
      rdy_b = m_init && !m_busy && (m_edge >= m_idle_from);
      vld_b = m_busy && (m_edge >= m_resp_at);
      m_edge++;
      if (rst) begin
         m_init = 1'b1;
         m_busy = 1'b0;
         m_idle_from = m_edge + WORDS;
         for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
      end else if (rdy_b && req_valid) begin
         nb  = (req_size == 2'b00) ? 1 : (req_size == 2'b01) ? 2 : 4;
         a   = {32'd0, req_addr};
         err = (req_size == 2'b11) || (a % nb != 0) || (a + nb > DEPTH);
         m_rdata = '0;
         m_err   = err;
         if (!err && req_write) begin
            for (int i = 0; i < nb; i++) m_mem[int'(a) + i] = 8'(req_wdata >> (8 * (nb - 1 - i)));
         end else if (!err) begin
            v = '0;
            for (int i = 0; i < nb; i++) v = {v[23:0], m_mem[int'(a) + i]};
            if (req_signed && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
            m_rdata = v;
         end
         m_busy = 1'b1;
         m_resp_at = m_edge + LAT;
      end else if (vld_b && resp_ready) begin
         m_busy = 1'b0;
         m_idle_from = m_edge;
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (m_init) begin
         bit vld;
         vld = m_busy && (m_edge >= m_resp_at);
         check("req_ready", req_ready, !m_busy && (m_edge >= m_idle_from));
         check("resp_valid", resp_valid, vld);
         check("resp_rdata", resp_rdata, vld ? m_rdata : 32'd0);
         check("resp_err", resp_err, vld ? m_err : 1'b0);
      end
   end

   task automatic do_reset(output int low);
      rst = 1'b1;
      req_valid = 1'b0;
      resp_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      low = 0;
      while (req_ready !== 1'b1 && low < 1000) begin
         low++;
         @(negedge clk);
      end
   endtask

   task automatic issue(input bit wr, input logic [31:0] addr, input logic [1:0] sz, input bit sg,
                        input logic [31:0] wd, output bit ok);
      req_valid = 1'b1;
      req_write = wr;
      req_addr = addr;
      req_size = sz;
      req_signed = sg;
      req_wdata = wd;
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (req_ready === 1'b1) begin
            @(posedge clk);
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) @(negedge clk);
      req_valid = 1'b0;
      req_write = 1'($urandom_range(0, 1));
      req_addr = $urandom;
      req_size = 2'($urandom_range(0, 3));
      req_signed = 1'($urandom_range(0, 1));
      req_wdata = $urandom;
      check("accept", ok, 1);
   endtask

   task automatic get_resp(input int hold, output logic [31:0] rd, output logic er,
                           output int lat, output bit stable);
      bit got;
      got = 1'b0;
      lat = 0;
      rd = '0;
      er = 1'b0;
      stable = 1'b1;
      for (int i = 1; i <= 64; i++) begin
         if (resp_valid === 1'b1) begin
            got = 1'b1;
            lat = i;
            break;
         end
         resp_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      check("resp_seen", got, 1);
      if (!got) begin
         resp_ready = 1'b0;
         return;
      end
      rd = resp_rdata;
      er = resp_err;
      resp_ready = (hold == 0);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_err !== er || req_ready !== 1'b0)
            stable = 1'b0;
      end
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   task automatic xact(input bit wr, input logic [31:0] addr, input logic [1:0] sz, input bit sg,
                       input logic [31:0] wd, input int hold, output logic [31:0] rd,
                       output logic er, output int lat, output bit stable);
      bit ok;
      issue(wr, addr, sz, sg, wd, ok);
      rd = '0;
      er = 1'b0;
      lat = 0;
      stable = 1'b0;
      if (ok) get_resp(hold, rd, er, lat, stable);
   endtask

   task automatic op(input string name, input bit wr, input logic [31:0] addr, input logic [1:0] sz,
                     input bit sg, input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_er);
      logic [31:0] rd;
      logic        er;
      int          lat;
      bit          st;
      xact(wr, addr, sz, sg, wd, $urandom_range(0, 2), rd, er, lat, st);
      check({name, "_rdata"}, rd, exp_rd);
      check({name, "_err"}, er, exp_er);
   endtask

   initial begin
      int          low;
      int          lat;
      bit          st, ok;
      logic [31:0] rd;
      logic        er;
      int          r;
      bit          wr, sg;
      logic [1:0]  sz;
      logic [31:0] addr, wd;

      @(negedge clk);
      do_reset(low);
      check("clear_cycles", low, 256);

      xact(1'b0, 32'h000, SIZE_WORD, 1'b0, 32'h0, 0, rd, er, lat, st);
      check("first_load_rdata", rd, 32'h0000_0000);
      check("first_load_latency", lat - 1, LAT);

      op("store_deadbeef", 1'b1, 32'h010, SIZE_WORD, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0);
      op("lb_signed", 1'b0, 32'h011, SIZE_BYTE, 1'b1, 32'h0, 32'hFFFF_FFAD, 1'b0);
      op("lb_unsigned", 1'b0, 32'h011, SIZE_BYTE, 1'b0, 32'h0, 32'h0000_00AD, 1'b0);
      op("lh_signed", 1'b0, 32'h012, SIZE_HALF, 1'b1, 32'h0, 32'hFFFF_BEEF, 1'b0);

      op("store_aaaa", 1'b1, 32'h020, SIZE_WORD, 1'b0, 32'hAAAA_AAAA, 32'h0, 1'b0);
      op("store_half", 1'b1, 32'h022, SIZE_HALF, 1'b0, 32'h5555_1234, 32'h0, 1'b0);
      op("lw_merged", 1'b0, 32'h020, SIZE_WORD, 1'b1, 32'h0, 32'hAAAA_1234, 1'b0);

      op("err_lw_002", 1'b0, 32'h002, SIZE_WORD, 1'b0, 32'h0, 32'h0, 1'b1);
      op("err_lh_001", 1'b0, 32'h001, SIZE_HALF, 1'b0, 32'h0, 32'h0, 1'b1);
      op("err_size11", 1'b0, 32'h020, SIZE_ILLEGAL, 1'b0, 32'h0, 32'h0, 1'b1);
      op("err_lw_3fe", 1'b0, 32'h3FE, SIZE_WORD, 1'b0, 32'h0, 32'h0, 1'b1);
      op("err_lw_400", 1'b0, 32'h400, SIZE_WORD, 1'b0, 32'h0, 32'h0, 1'b1);
      op("err_sw_022", 1'b1, 32'h022, SIZE_WORD, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1);
      op("err_s11_020", 1'b1, 32'h020, SIZE_ILLEGAL, 1'b0, 32'h0, 32'h0, 1'b1);
      op("lw_unchanged", 1'b0, 32'h020, SIZE_WORD, 1'b0, 32'h0, 32'hAAAA_1234, 1'b0);
      op("lw_3fc_edge", 1'b0, 32'h3FC, SIZE_WORD, 1'b0, 32'h0, 32'h0, 1'b0);

      xact(1'b0, 32'h020, SIZE_WORD, 1'b0, 32'h0, 5, rd, er, lat, st);
      check("hold_latency", lat - 1, LAT);
      check("hold_stable", st, 1);
      check("hold_rdata", rd, 32'hAAAA_1234);

      issue(1'b1, 32'h004, SIZE_BYTE, 1'b0, 32'h55, ok);
      check("wait_no_valid", resp_valid, 0);
      do_reset(low);
      check("clear_cycles_again", low, 256);
      op("lw_after_reset", 1'b0, 32'h004, SIZE_WORD, 1'b0, 32'h0, 32'h0, 1'b0);
      op("lw_deadbeef_gone", 1'b0, 32'h010, SIZE_WORD, 1'b0, 32'h0, 32'h0, 1'b0);

      for (int t = 0; t < 400; t++) begin
         r  = int'($urandom_range(0, 99));
         wr = 1'($urandom_range(0, 1));
         sz = (r < 6) ? 2'b11 : 2'($urandom_range(0, 2));
         if (r >= 6 && r < 12) addr = 32'h3F0 + $urandom_range(0, 31);
         else if (r == 12) addr = $urandom;
         else addr = $urandom_range(0, 63);
         if (r >= 20) begin
            if (sz == 2'b01) addr[0] = 1'b0;
            else if (sz == 2'b10) addr[1:0] = 2'b00;
         end
         wd = $urandom;
         sg = 1'($urandom_range(0, 1));
         issue(wr, addr, sz, sg, wd, ok);
         if (ok && $urandom_range(0, 39) == 0) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_reset(low);
            check("rand_clear_cycles", low, 256);
         end else if (ok) begin
            get_resp(int'($urandom_range(0, 3)), rd, er, lat, st);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog at %0t: got timeout want finish", $time);
      $fatal(1, "watchdog");
   end

endmodule
